// File: rtl/collatz_inverse_walker.sv
// Reverse-Collatz walker: from a seed, takes one predecessor step per clock,
// with a path bit choosing between the (n-1)/3 branch and the 2n branch.
module collatz_inverse_walker #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_STEPS = 16,
    parameter int unsigned CW        = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     seed,
    input  logic [CW-1:0]        num_steps,
    input  logic [MAX_STEPS-1:0] path,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 err,
    output logic [WIDTH-1:0]     value,
    output logic [CW-1:0]        steps_done,
    output logic [CW-1:0]        odd_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     value_q, value_d;
    logic [CW-1:0]        steps_q, steps_d;
    logic [CW-1:0]        odd_q, odd_d;
    logic [CW-1:0]        nsteps_q, nsteps_d;
    logic [MAX_STEPS-1:0] path_q, path_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;

    // Step datapath: branch selection and exact divide-by-3 of n-1
    logic [WIDTH-1:0] n_dec;
    logic [WIDTH-1:0] n_div3;
    logic [WIDTH-1:0] n_mod6;
    logic             eligible;
    logic             path_bit;
    logic [CW-1:0]    steps_inc;

    assign n_dec     = value_q - WIDTH'(1);
    assign n_div3    = n_dec / WIDTH'(3);
    assign n_mod6    = value_q % WIDTH'(6);
    assign eligible  = (n_mod6 == WIDTH'(4)) && (value_q != WIDTH'(4));
    assign path_bit  = |(path_q & (MAX_STEPS'(1) << steps_q));
    assign steps_inc = steps_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        steps_d  = steps_q;
        odd_d    = odd_q;
        nsteps_d = nsteps_q;
        path_d   = path_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    steps_d  = '0;
                    odd_d    = '0;
                    value_d  = seed;
                    path_d   = path;
                    nsteps_d = num_steps;
                    if ((seed == '0) || (num_steps > CW'(MAX_STEPS))) begin
                        err_d   = 1'b1;
                        value_d = '0;
                        state_d = S_DONE;
                    end else if (num_steps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Overflow aborts without counting the step
                if (path_bit && eligible) begin
                    value_d = n_div3;
                    odd_d   = odd_q + CW'(1);
                    steps_d = steps_inc;
                    if (steps_inc == nsteps_q) state_d = S_DONE;
                end else if (value_q[WIDTH-1]) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    value_d = value_q << 1;
                    steps_d = steps_inc;
                    if (steps_inc == nsteps_q) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            value_q  <= '0;
            steps_q  <= '0;
            odd_q    <= '0;
            nsteps_q <= '0;
            path_q   <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            steps_q  <= steps_d;
            odd_q    <= odd_d;
            nsteps_q <= nsteps_d;
            path_q   <= path_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign overflow   = ovf_q;
    assign err        = err_q;
    assign value      = value_q;
    assign steps_done = steps_q;
    assign odd_count  = odd_q;

endmodule

// File: doc/collatz_inverse_walker.md
# collatz_inverse_walker

Sequential reverse-Collatz generator: starting from a seed, it walks the Collatz predecessor tree backwards for a programmed number of steps, one step per clock. A path bit-vector chooses the branch at each step. It complements the existing forward single-step Collatz logic, and its results can be cross-checked against it: applying the forward rule `steps_done` times to the final `value` must return the seed. It sits behind the Tiny Tapeout top-level I/O alongside that forward logic.

## Interface
- WIDTH, 16, datapath width of seed/value.
- MAX_STEPS, 16, maximum steps per run; path vector length.
- CW, 5, width of step counters; must satisfy 2^CW > MAX_STEPS.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- start  in  1  run request; sampled only in IDLE or DONE.
- seed  in  WIDTH  starting value; sampled with start.
- num_steps  in  CW  requested step count; sampled with start.
- path  in  MAX_STEPS  branch choices; bit i is used at step i; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- overflow  out  1  run ended early because a doubling would exceed WIDTH; valid in DONE.
- err  out  1  bad arguments were given; valid in DONE.
- value  out  WIDTH  current or final walk value.
- steps_done  out  CW  steps completed so far.
- odd_count  out  CW  number of (n-1)/3 branches taken.

## Operation
- FSM states and outputs:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1, held until the next accepted start or reset.
- start in IDLE or DONE:
  - Clears overflow, err, steps_done and odd_count.
  - Loads value=seed and latches path and num_steps.
  - Next state:
    - seed==0 or num_steps>MAX_STEPS: DONE with err=1, value=0.
    - num_steps==0: DONE, value=seed.
    - otherwise: RUN.
- start while in RUN is ignored, and the inputs are not resampled.
- Step rule in RUN, with n=value and i=steps_done:
  - eligible = (n mod 6 == 4) && (n != 4). The 4→1 edge is excluded to avoid the trivial cycle.
  - If path[i]==1 and eligible: value ← (n-1)/3 and odd_count+1. The result is always odd and always fits.
  - Else if n[WIDTH-1]==1: the doubling would overflow.
    - overflow=1 and the state goes to DONE.
    - value, steps_done and odd_count are unchanged; the step is not counted.
  - Else: value ← n<<1.
  - On a successful step, steps_done+1. If the new steps_done == latched num_steps, the state goes to DONE.
- Divide-by-3 is exact: it is only applied when n-1 ≡ 0 mod 3. It may be combinational (constant multiply) or a shift-add network, but it must complete within one cycle.
- Arithmetic is unsigned. Values wrap nowhere; overflow is detected before any doubling.
- rst_n low at any time, including mid-run:
  - State goes to IDLE immediately.
  - All outputs and internal registers go to 0.
  - The in-flight run is discarded.

## Timing
- Reset values: busy=0, done=0, overflow=0, err=0, value=0, steps_done=0, odd_count=0.
- Start accepted at edge E0 → busy=1 after E0. Exceptions: err or num_steps==0 go straight to done=1 after E0.
- Step k (1..N) is performed at edge Ek, and value updates after that edge.
- done rises after EN, with busy falling at the same edge. Latency is N cycles from the start edge.
- On overflow at edge Ek: done=1 after Ek, steps_done=k-1.
- A start in DONE at edge Ex begins a new run. done falls after Ex, with the same timing as from IDLE.
- All outputs are registered; there are no combinational paths from the inputs.

## Test plan
- Pure doubling: seed=1, num_steps=4, path=0 → busy for 4 cycles. Then value=16, steps_done=4, odd_count=0, done=1 4 cycles after start.
- Odd branches: seed=16, num_steps=3, path=0b101.
  - Expected walk: 16→5→10→3.
  - Final: value=3, odd_count=2, overflow=0.
  - Forward check: 3→10→5→16.
- Excluded edge: seed=4, num_steps=2, path=all ones → walk 4→8→16, value=16, odd_count=0.
- Overflow: WIDTH=16, seed=0x4000, num_steps=3, path=0 → value=0x8000, steps_done=1, overflow=1, done asserted 2 cycles after start.
- Bad arguments: seed=0 → done=1, err=1, value=0 after 1 cycle. num_steps=17 gives the same result.
- Control corners:
  - Reset mid-run: pull rst_n low at step 2 of an 8-step run → all outputs 0 and IDLE.
  - Start pulse during RUN: ignored, final value unchanged.
  - Back-to-back start in DONE: the new run starts at that edge with fresh counters.
